sysid_ext: RTL and testbench

- Parametrised system-identification slave on the Avalon-MM bus; next generation of the fixed ID/timestamp ROM.
- Read-only words: system ID, build timestamp, up to 8 user build words (e.g. firmware revision, board variant).
- Also provides a writable scratch register and a free-running 64-bit uptime counter with atomic two-word readout.
- Lets host software confirm it is talking to the intended bitstream, probe bus health, and time-stamp events.

---
 rtl/sysid_ext.sv | 127 ++++++++++++
 tb/tb_sysid_ext.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sysid_ext.sv
// System-identification Avalon-MM slave: ID/timestamp/user ROM words, scratch,
// and a prescaled 64-bit uptime counter with LO-triggered HI snapshot.
module sysid_ext #(
  parameter logic [31:0]  ID_VALUE        = 32'd1306474855,
  parameter logic [31:0]  TIMESTAMP_VALUE = 32'd1305651299,
  parameter int           ADDR_WIDTH      = 4,
  parameter int           NUM_USER_WORDS  = 2,
  parameter logic [255:0] USER_WORDS      = 256'h0,
  parameter int           PRESCALE        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic                  readdatavalid,
  output logic [63:0]           uptime
);

  if ((ADDR_WIDTH < 3) || (NUM_USER_WORDS < 0) || (NUM_USER_WORDS > 8) ||
      ((6 + NUM_USER_WORDS) > (1 << ADDR_WIDTH)) ||
      (PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_params
    $error("sysid_ext: illegal parameter combination");
  end

  localparam logic [ADDR_WIDTH-1:0] A_ID    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_TS    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_SCR   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_UPLO  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_UPHI  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'(5);
  localparam logic [15:0]           PRESC_LAST = 16'(PRESCALE - 1);

  logic [31:0] r_scratch;
  logic        r_freeze;
  logic [15:0] r_presc;
  logic [63:0] r_uptime;
  logic [31:0] r_hi_shadow;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic        w_wr_ctrl;
  logic        w_clr;
  logic        w_tick;
  logic [31:0] w_user;
  logic [31:0] w_rdata;

  assign w_wr_ctrl     = write && (address == A_CTRL);
  assign w_clr         = w_wr_ctrl && writedata[0];
  assign w_tick        = (r_presc == PRESC_LAST);
  assign readdata      = r_rdata;
  assign readdatavalid = r_rvalid;
  assign uptime        = r_uptime;

  // User word lookup; at most one slot matches, so OR-accumulation is a mux.
  always_comb begin
    w_user = 32'h0;
    for (int k = 0; k < 8; k++) begin
      w_user = w_user |
               (((k < NUM_USER_WORDS) && (32'(address) == 32'(6 + k))) ?
                USER_WORDS[32*k +: 32] : 32'h0);
    end
  end

  // Read-data decode from current (pre-write) register state.
  always_comb begin
    w_rdata = 32'h0;
    case (address)
      A_ID:    w_rdata = ID_VALUE;
      A_TS:    w_rdata = TIMESTAMP_VALUE;
      A_SCR:   w_rdata = r_scratch;
      A_UPLO:  w_rdata = r_uptime[31:0];
      A_UPHI:  w_rdata = r_hi_shadow;
      A_CTRL:  w_rdata = {30'h0, r_freeze, 1'b0};
      default: w_rdata = w_user;
    endcase
  end

  // Writable registers: byte-lane scratch and CTRL.FREEZE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scratch <= 32'h0;
      r_freeze  <= 1'b0;
    end else begin
      if (write && (address == A_SCR)) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) r_scratch[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
      if (w_wr_ctrl) r_freeze <= writedata[1];
    end
  end

  // Prescaler and uptime counter; CLR outranks any tick in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_presc  <= 16'h0;
      r_uptime <= 64'h0;
    end else if (!r_freeze) begin
      if (w_tick) begin
        r_presc  <= 16'h0;
        r_uptime <= r_uptime + 64'h1;
      end else begin
        r_presc  <= r_presc + 16'h1;
      end
    end
  end

  // Registered read path; a LO read snapshots the upper half for a later HI read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata     <= 32'h0;
      r_rvalid    <= 1'b0;
      r_hi_shadow <= 32'h0;
    end else begin
      r_rvalid <= read;
      if (read) begin
        r_rdata <= w_rdata;
        if (address == A_UPLO) r_hi_shadow <= r_uptime[63:32];
      end
    end
  end

endmodule

// File: tb/tb_sysid_ext.sv
// Directed bench for sysid_ext: one PRESCALE=4 instance with user words and
// one PRESCALE=1 instance without, sharing the same bus stimulus.
module tb_sysid_ext;
  localparam logic [31:0] ID = 32'd1306474855;
  localparam logic [31:0] TS = 32'd1305651299;

  logic        clk = 1'b0;
  logic        reset, read, write;
  logic [3:0]  address, byteenable;
  logic [31:0] writedata;
  logic [31:0] rd4, rd1;
  logic        rdv4, rdv1;
  logic [63:0] up4, up1;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sysid_ext #(.ADDR_WIDTH(4), .NUM_USER_WORDS(2), .PRESCALE(4),
              .USER_WORDS({192'h0, 32'h0000_0102, 32'h0000_0007})) dut4 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .readdata(rd4), .readdatavalid(rdv4), .uptime(up4));

  sysid_ext #(.ADDR_WIDTH(4), .NUM_USER_WORDS(0), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .readdata(rd1), .readdatavalid(rdv1), .uptime(up1));

  // Bus tasks start and end on a falling edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (rdv4 !== 1'b0) begin bad++; $display("FAIL reset_rdv got=%b exp=0", rdv4); end
    total++; if (rd4 !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rd4); end
    total++; if (up4 !== 64'h0) begin bad++; $display("FAIL reset_uptime4 got=%h exp=0", up4); end
    total++; if (up1 !== 64'h0) begin bad++; $display("FAIL reset_uptime1 got=%h exp=0", up1); end
    reset = 1'b0;
    rd(4'd4);
    total++; if (rd4 !== 32'h0 || rdv4 !== 1'b1) begin bad++; $display("FAIL hi_after_reset got=%h/%b exp=0/1", rd4, rdv4); end
  endtask

  task automatic test_id_ts();
    address = 4'd0; read = 1'b1;
    @(negedge clk);
    total++; if (rd4 !== ID || rdv4 !== 1'b1) begin bad++; $display("FAIL id_read got=%h/%b exp=%h/1", rd4, rdv4, ID); end
    address = 4'd1;
    @(negedge clk);
    total++; if (rd4 !== TS || rdv4 !== 1'b1) begin bad++; $display("FAIL ts_read got=%h/%b exp=%h/1", rd4, rdv4, TS); end
    read = 1'b0;
    @(negedge clk);
    total++; if (rdv4 !== 1'b0 || rd4 !== TS) begin bad++; $display("FAIL rdata_hold got=%h/%b exp=%h/0", rd4, rdv4, TS); end
  endtask

  task automatic test_scratch();
    wr(4'd2, 32'hA5A5_A5A5, 4'hF);
    wr(4'd2, 32'h0000_1234, 4'b0011);
    rd(4'd2);
    total++; if (rd4 !== 32'hA5A5_1234) begin bad++; $display("FAIL scratch_be got=%h exp=a5a51234", rd4); end
    wr(4'd0, 32'hDEAD_BEEF, 4'hF);
    rd(4'd0);
    total++; if (rd4 !== ID) begin bad++; $display("FAIL ro_write got=%h exp=%h", rd4, ID); end
    address = 4'd2; read = 1'b1; write = 1'b1; writedata = 32'h1111_1111; byteenable = 4'hF;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    total++; if (rd4 !== 32'hA5A5_1234) begin bad++; $display("FAIL rw_same_cycle got=%h exp=a5a51234", rd4); end
    rd(4'd2);
    total++; if (rd4 !== 32'h1111_1111) begin bad++; $display("FAIL rw_commit got=%h exp=11111111", rd4); end
  endtask

  task automatic test_prescale();
    wr(4'd5, 32'h1, 4'hF);
    total++; if (up4 !== 64'h0 || up1 !== 64'h0) begin bad++; $display("FAIL clr_start got=%h/%h exp=0/0", up4, up1); end
    repeat (40) @(negedge clk);
    total++; if (up4 !== 64'd10) begin bad++; $display("FAIL presc_live got=%0d exp=10", up4); end
    rd(4'd3);
    total++; if (rd4 !== 32'd10) begin bad++; $display("FAIL presc_read4 got=%0d exp=10", rd4); end
    total++; if (rd1 !== 32'd40) begin bad++; $display("FAIL presc_read1 got=%0d exp=40", rd1); end
    wr(4'd5, 32'h2, 4'hF);
    rd(4'd3);
    total++; if (rd4 !== 32'd10 || rd1 !== 32'd42) begin bad++; $display("FAIL freeze_a got=%0d/%0d exp=10/42", rd4, rd1); end
    repeat (100) @(negedge clk);
    rd(4'd3);
    total++; if (rd4 !== 32'd10 || rd1 !== 32'd42) begin bad++; $display("FAIL freeze_b got=%0d/%0d exp=10/42", rd4, rd1); end
    rd(4'd5);
    total++; if (rd4 !== 32'h2) begin bad++; $display("FAIL ctrl_read got=%h exp=2", rd4); end
  endtask

  task automatic test_clr();
    wr(4'd5, 32'h0, 4'hF);
    @(negedge clk);
    wr(4'd5, 32'h1, 4'hF);
    total++; if (up1 !== 64'h0 || up4 !== 64'h0) begin bad++; $display("FAIL clr_priority got=%h/%h exp=0/0", up1, up4); end
    @(negedge clk);
    total++; if (up1 !== 64'h1) begin bad++; $display("FAIL clr_resume got=%h exp=1", up1); end
    rd(4'd5);
    total++; if (rd4 !== 32'h0) begin bad++; $display("FAIL clr_reads0 got=%h exp=0", rd4); end
    wr(4'd5, 32'h3, 4'hF);
    repeat (5) @(negedge clk);
    total++; if (up1 !== 64'h0 || up4 !== 64'h0) begin bad++; $display("FAIL clr_freeze got=%h/%h exp=0/0", up1, up4); end
    rd(4'd5);
    total++; if (rd4 !== 32'h2) begin bad++; $display("FAIL clr_freeze_ctrl got=%h exp=2", rd4); end
  endtask

  task automatic test_atomic();
    force dut1.r_uptime = 64'h0000_0000_FFFF_FFFD;
    @(negedge clk);
    release dut1.r_uptime;
    total++; if (up1 !== 64'h0000_0000_FFFF_FFFD) begin bad++; $display("FAIL preload got=%h exp=fffffffd", up1); end
    wr(4'd5, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    total++; if (up1 !== 64'h0000_0000_FFFF_FFFF) begin bad++; $display("FAIL pre_carry got=%h exp=ffffffff", up1); end
    rd(4'd3);
    total++; if (rd1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL atomic_lo got=%h exp=ffffffff", rd1); end
    total++; if (up1 !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL carry got=%h exp=100000000", up1); end
    repeat (3) @(negedge clk);
    rd(4'd4);
    total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL atomic_hi got=%h exp=0", rd1); end
    rd(4'd3);
    rd(4'd4);
    total++; if (rd1 !== 32'h1) begin bad++; $display("FAIL atomic_hi2 got=%h exp=1", rd1); end
  endtask

  task automatic test_user();
    rd(4'd6);
    total++; if (rd4 !== 32'h7) begin bad++; $display("FAIL user0 got=%h exp=7", rd4); end
    total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL user_none got=%h exp=0", rd1); end
    rd(4'd7);
    total++; if (rd4 !== 32'h102) begin bad++; $display("FAIL user1 got=%h exp=102", rd4); end
    rd(4'd8);
    total++; if (rd4 !== 32'h0) begin bad++; $display("FAIL unmapped8 got=%h exp=0", rd4); end
    rd(4'd15);
    total++; if (rd4 !== 32'h0) begin bad++; $display("FAIL unmapped15 got=%h exp=0", rd4); end
  endtask

  task automatic test_reset_mid();
    address = 4'd0; read = 1'b1; reset = 1'b1;
    @(negedge clk);
    read = 1'b0; reset = 1'b0;
    total++; if (rdv4 !== 1'b0 || rd4 !== 32'h0) begin bad++; $display("FAIL reset_drop got=%h/%b exp=0/0", rd4, rdv4); end
    wr(4'd2, 32'h0000_0055, 4'hF);
    wr(4'd5, 32'h2, 4'hF);
    address = 4'd2; read = 1'b1;
    @(negedge clk);
    total++; if (rdv4 !== 1'b1 || rd4 !== 32'h55) begin bad++; $display("FAIL pre_reset_read got=%h/%b exp=55/1", rd4, rdv4); end
    read = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (rdv4 !== 1'b0 || rd4 !== 32'h0 || up1 !== 64'h0) begin bad++; $display("FAIL reset_after_read got=%h/%b/%h exp=0/0/0", rd4, rdv4, up1); end
    rd(4'd2);
    total++; if (rd4 !== 32'h0) begin bad++; $display("FAIL scratch_reset got=%h exp=0", rd4); end
    rd(4'd5);
    total++; if (rd4 !== 32'h0) begin bad++; $display("FAIL freeze_reset got=%h exp=0", rd4); end
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0;
    address = 4'd0; writedata = 32'h0; byteenable = 4'h0;
    @(negedge clk);
    test_reset();
    test_id_ts();
    test_scratch();
    test_prescale();
    test_clr();
    test_atomic();
    test_user();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
